// File: rtl/counter_pkg.sv
// Shared encodings and helpers for the modulo counter family.
//   MODE_WRAP / MODE_SAT : boundary behaviour select
//   DIR_DOWN / DIR_UP    : count direction select
//   clamp_to_max         : limit a value to modulus-1 (17-bit, covers WIDTH up to 16)
package counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

    localparam int unsigned CALC_W = 17;

    // Values at or above the modulus collapse onto the top of the range.
    function automatic logic [CALC_W-1:0] clamp_to_max(input logic [CALC_W-1:0] value,
                                                      input logic [CALC_W-1:0] modulus);
        return (value >= modulus) ? (modulus - CALC_W'(1)) : value;
    endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-count and wrap detection for mod_counter.
//   Out      : current count
//   In       : parallel load value (clamped to MAX)
//   Load     : load has priority over Count
//   Count    : step enable
//   Up       : direction (DIR_UP / DIR_DOWN)
//   Mode     : boundary behaviour (MODE_WRAP / MODE_SAT)
//   next_out : count value for the next edge (reset excluded)
//   wrap     : a wrap happens on the next edge
module mod_counter_next
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic [WIDTH-1:0] Out,
    input  logic [WIDTH-1:0] In,
    input  logic             Load,
    input  logic             Count,
    input  logic             Up,
    input  logic             Mode,
    output logic [WIDTH-1:0] next_out,
    output logic             wrap
);

    localparam int unsigned XW = WIDTH + 1;
    localparam logic [XW-1:0] MAX = XW'(MODULUS - 1);

    logic [XW-1:0] cur;
    logic [XW-1:0] load_val;
    logic [XW-1:0] nxt;

    assign cur      = {1'b0, Out};
    assign load_val = XW'(clamp_to_max(CALC_W'(In), CALC_W'(MODULUS)));

    // Extra headroom bit keeps MAX+1 comparisons exact when MODULUS = 2**WIDTH.
    always_comb begin
        nxt  = cur;
        wrap = 1'b0;
        if (Load) begin
            nxt = load_val;
        end else if (Count) begin
            if (Up == DIR_UP) begin
                if (cur < MAX) begin
                    nxt = cur + XW'(1);
                end else if (Mode == MODE_WRAP) begin
                    nxt  = '0;
                    wrap = 1'b1;
                end
            end else begin
                if (cur != '0) begin
                    nxt = cur - XW'(1);
                end else if (Mode == MODE_WRAP) begin
                    nxt  = MAX;
                    wrap = 1'b1;
                end
            end
        end
    end

    assign next_out = WIDTH'(nxt);

endmodule

// File: rtl/mod_counter.sv
// Parametrised modulo counter with load, up/down, wrap/saturate and cascade carry.
//   Clock     : rising-edge clock
//   Reset     : synchronous active-high reset
//   In/Load   : parallel load (clamped to MAX)
//   Count     : count enable
//   Up        : direction, Mode : wrap (0) / saturate (1)
//   Out       : registered count
//   TermCount : combinational carry/borrow for the next stage's Count
//   WrapPulse : registered one-cycle pulse after a wrap
//   AtLimit   : registered, Out at the boundary of the sampled direction
module mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned MODULUS     = 16,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] In,
    input  logic             Load,
    input  logic             Count,
    input  logic             Up,
    input  logic             Mode,
    output logic [WIDTH-1:0] Out,
    output logic             TermCount,
    output logic             WrapPulse,
    output logic             AtLimit
);

    localparam logic [WIDTH-1:0] MAX     = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] next_out;
    logic [WIDTH-1:0] d_out;
    logic             wrap;

    mod_counter_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .Out      (Out),
        .In       (In),
        .Load     (Load),
        .Count    (Count),
        .Up       (Up),
        .Mode     (Mode),
        .next_out (next_out),
        .wrap     (wrap)
    );

    assign d_out = Reset ? RST_VAL : next_out;

    // AtLimit looks at the value being written so it lines up with Out.
    always_ff @(posedge Clock) begin
        Out       <= d_out;
        WrapPulse <= wrap & ~Reset;
        AtLimit   <= (Up == DIR_UP) ? (d_out == MAX) : (d_out == '0);
    end

    assign TermCount = Count & ~Load & ~Reset &
                       ((Up == DIR_UP) ? (Out == MAX) : (Out == '0));

endmodule
